// File: rtl/ff_conv_pkg.sv
// Shared definitions for the flip-flop conversion blocks: excitation word layout,
// transition codes and the excitation function itself.
package ff_conv_pkg;

  localparam int EXC_W = 5;
  localparam int EXC_S = 4;
  localparam int EXC_R = 3;
  localparam int EXC_J = 2;
  localparam int EXC_K = 1;
  localparam int EXC_T = 0;

  localparam logic [1:0] TR_HOLD0 = 2'd0;
  localparam logic [1:0] TR_HOLD1 = 2'd1;
  localparam logic [1:0] TR_SET   = 2'd2;
  localparam logic [1:0] TR_CLR   = 2'd3;

  function automatic logic [1:0] tr_code(input logic q, input logic d);
    logic [1:0] c;
    case ({q, d})
      2'b00:   c = TR_HOLD0;
      2'b01:   c = TR_SET;
      2'b10:   c = TR_CLR;
      default: c = TR_HOLD1;
    endcase
    return c;
  endfunction

  // Word is {S,R,J,K,T}; dc_one picks how the don't-care entries resolve.
  function automatic logic [EXC_W-1:0] excite(input logic q, input logic d, input logic dc_one);
    logic [EXC_W-1:0] w;
    w = '0;
    if (dc_one) begin
      w[EXC_S] = d;
      w[EXC_R] = ~d;
      w[EXC_J] = q | d;
      w[EXC_K] = ~(q & d);
    end else begin
      w[EXC_S] = ~q & d;
      w[EXC_R] = q & ~d;
      w[EXC_J] = ~q & d;
      w[EXC_K] = q & ~d;
    end
    w[EXC_T] = q ^ d;
    return w;
  endfunction

endpackage

// File: rtl/sr_ff.sv
// Present-state register built as an SR flip-flop; flags the illegal S=R=1 input.
module sr_ff (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qb,
  output logic illegal
);

  assign qb      = ~q;
  assign illegal = s & r;

  // S=R=1 holds state; the condition is reported rather than resolved.
  always_ff @(posedge clk) begin
    if (!rst)
      q <= 1'b0;
    else if (s && !r)
      q <= 1'b1;
    else if (r && !s)
      q <= 1'b0;
  end

endmodule

// File: rtl/ff_excitation_gen.sv
// Turns a stream of target next-state bits into SR/JK/T excitation words, with
// a one-entry output register, per-transition counters and a sticky error flag.
module ff_excitation_gen
  import ff_conv_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DC_ONE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic             r,
  output logic             j,
  output logic             k,
  output logic             t,
  output logic             q_prev,
  output logic             q_next,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_hold,
  output logic [CNT_W-1:0] cnt_set,
  output logic [CNT_W-1:0] cnt_clear,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             q, qb, illegal, accept, chk_pend, mismatch;
  logic [EXC_W-1:0] exc, word;
  logic [1:0]       tr;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign exc      = excite(q, d_in, DC_ONE != 0);
  assign tr       = tr_code(q, d_in);

  sr_ff u_sr_ff (
    .clk     (clk),
    .rst     (rst),
    .s       (accept & exc[EXC_S]),
    .r       (accept & exc[EXC_R]),
    .q       (q),
    .qb      (qb),
    .illegal (illegal)
  );

  assign s = word[EXC_S];
  assign r = word[EXC_R];
  assign j = word[EXC_J];
  assign k = word[EXC_K];
  assign t = word[EXC_T];

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      word      <= '0;
      q_prev    <= 1'b0;
      q_next    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      word      <= exc;
      q_prev    <= q;
      q_next    <= d_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      cnt_hold  <= '0;
      cnt_set   <= '0;
      cnt_clear <= '0;
    end else if (accept) begin
      case (tr)
        TR_SET:  if (cnt_set   != CNT_MAX) cnt_set   <= cnt_set + 1'b1;
        TR_CLR:  if (cnt_clear != CNT_MAX) cnt_clear <= cnt_clear + 1'b1;
        default: if (cnt_hold  != CNT_MAX) cnt_hold  <= cnt_hold + 1'b1;
      endcase
    end
  end

  // q_next holds the last accepted target, so one cycle after an accept the
  // register must agree with it.
  assign mismatch = chk_pend && (q_next ? qb : q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err      <= 1'b0;
      chk_pend <= 1'b0;
    end else begin
      chk_pend <= accept;
      if (cnt_clr)
        err <= 1'b0;
      else if ((accept && illegal) || mismatch)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ff_excitation_gen.sv
// Directed bench: three instances (DC_ONE=0, DC_ONE=1, CNT_W=2) share one input stream.
module tb_ff_excitation_gen;

  logic       clk = 1'b0;
  logic       rst, d_in, in_valid, out_ready, cnt_clr;
  logic [2:0] in_ready, out_valid, s, r, j, k, t, q_prev, q_next, err;
  logic [7:0] ch0, cs0, cc0, ch1, cs1, cc1;
  logic [1:0] ch2, cs2, cc2;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  ff_excitation_gen #(.CNT_W(8), .DC_ONE(0)) dut0 (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .s(s[0]), .r(r[0]), .j(j[0]),
    .k(k[0]), .t(t[0]), .q_prev(q_prev[0]), .q_next(q_next[0]), .cnt_clr(cnt_clr),
    .cnt_hold(ch0), .cnt_set(cs0), .cnt_clear(cc0), .err(err[0]));

  ff_excitation_gen #(.CNT_W(8), .DC_ONE(1)) dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .s(s[1]), .r(r[1]), .j(j[1]),
    .k(k[1]), .t(t[1]), .q_prev(q_prev[1]), .q_next(q_next[1]), .cnt_clr(cnt_clr),
    .cnt_hold(ch1), .cnt_set(cs1), .cnt_clear(cc1), .err(err[1]));

  ff_excitation_gen #(.CNT_W(2), .DC_ONE(0)) dut2 (
    .clk(clk), .rst(rst), .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready), .s(s[2]), .r(r[2]), .j(j[2]),
    .k(k[2]), .t(t[2]), .q_prev(q_prev[2]), .q_next(q_next[2]), .cnt_clr(cnt_clr),
    .cnt_hold(ch2), .cnt_set(cs2), .cnt_clear(cc2), .err(err[2]));

  typedef struct {
    logic       d;
    logic [4:0] w_dc0;
    logic [4:0] w_dc1;
    logic       qp;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] wd(input int i);
    return {s[i], r[i], j[i], k[i], t[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {d_in, word DC_ONE=0, word DC_ONE=1, q_prev}, words as {S,R,J,K,T}
    vt[0] = '{1'b1, 5'b10101, 5'b10111, 1'b0};
    vt[1] = '{1'b1, 5'b00000, 5'b10100, 1'b1};
    vt[2] = '{1'b0, 5'b01011, 5'b01111, 1'b1};
    vt[3] = '{1'b0, 5'b00000, 5'b01010, 1'b0};

    rst = 1'b0; in_valid = 1'b1; d_in = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q_prev",    32'(q_prev),    32'd0);
    chk("rst_q_next",    32'(q_next),    32'd0);
    chk("rst_word0",     32'(wd(0)),     32'd0);
    chk("rst_cnts0",     {8'd0, ch0, cs0, cc0}, 32'd0);
    chk("rst_cnts2",     {26'd0, ch2, cs2, cc2}, 32'd0);
    chk("rst_err",       32'(err),       32'd0);

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_in = vt[i].d;
      tick();
      chk($sformatf("stream%0d_valid", i),  32'(out_valid[0]), 32'd1);
      chk($sformatf("stream%0d_dc0", i),    32'(wd(0)), 32'(vt[i].w_dc0));
      chk($sformatf("stream%0d_dc1", i),    32'(wd(1)), 32'(vt[i].w_dc1));
      chk($sformatf("stream%0d_qprev", i),  32'(q_prev[0]), 32'(vt[i].qp));
      chk($sformatf("stream%0d_qnext", i),  32'(q_next[1]), 32'(vt[i].d));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", 32'(out_valid[0]), 32'd0);
    chk("stream_cnt_set",   32'(cs0), 32'd1);
    chk("stream_cnt_clear", 32'(cc0), 32'd1);
    chk("stream_cnt_hold",  32'(ch0), 32'd2);
    chk("stream_err",       32'(err), 32'd0);

    // backpressure: hold the first word, then release with a new input waiting
    out_ready = 1'b0; in_valid = 1'b1; d_in = 1'b1;
    tick();
    chk("bp_first_valid", 32'(out_valid[0]), 32'd1);
    d_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready[0]), 32'd0);
      tick();
      chk($sformatf("bp_hold_word%0d", i), 32'(wd(0)), 32'b10101);
      chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid[0]), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready[0]), 32'd1);
    tick();
    chk("bp_second_word",  32'(wd(0)), 32'b01011);
    chk("bp_second_qprev", 32'(q_prev[0]), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", 32'(out_valid[0]), 32'd0);
    chk("bp_cnt_set",   32'(cs0), 32'd2);
    chk("bp_cnt_clear", 32'(cc0), 32'd2);
    chk("bp_cnt_hold",  32'(ch0), 32'd2);

    // saturation on the 2-bit counters
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnts2", {26'd0, ch2, cs2, cc2}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_in = 1'b1;
      tick();
      d_in = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("sat_cnt_set2",   32'(cs2), 32'd3);
    chk("sat_cnt_clear2", 32'(cc2), 32'd3);
    chk("sat_cnt_hold2",  32'(ch2), 32'd0);
    chk("sat_cnt_set0",   32'(cs0), 32'd6);
    chk("sat_cnt_clear0", 32'(cc0), 32'd6);

    cnt_clr = 1'b1; in_valid = 1'b1; d_in = 1'b1;
    tick();
    cnt_clr = 1'b0; in_valid = 1'b0;
    chk("clracc_cnts2", {26'd0, ch2, cs2, cc2}, 32'd0);
    chk("clracc_cnt_set0", 32'(cs0), 32'd0);
    chk("clracc_valid", 32'(out_valid[2]), 32'd1);
    chk("clracc_word",  32'(wd(2)), 32'b10101);

    // reset while a word is pending and q=1
    out_ready = 1'b0; rst = 1'b0; in_valid = 1'b1; d_in = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_word0", 32'(wd(0)), 32'd0);
    chk("midrst_qnext", 32'(q_next), 32'd0);
    chk("midrst_cnts0", {8'd0, ch0, cs0, cc0}, 32'd0);
    rst = 1'b1; out_ready = 1'b1; d_in = 1'b1;
    tick();
    chk("postrst_word0", 32'(wd(0)), 32'b10101);
    chk("postrst_word1", 32'(wd(1)), 32'b10111);
    chk("postrst_qprev", 32'(q_prev[0]), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("postrst_cnt_set0", 32'(cs0), 32'd1);
    chk("final_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
